// File: rtl/systolic_pkg.sv
// systolic_pkg: FSM state type and default sizing shared by the systolic MAC array blocks.
package systolic_pkg;
  typedef enum logic [0:0] {ST_COUNT = 1'b0, ST_FIRE = 1'b1} done_state_e;
  localparam int DONE_TARGET_DEF = 12;
  localparam int NUM_CH_DEF = 4;
endpackage

// File: rtl/done_ch_counter.sv
// done_ch_counter: saturating per-channel done counter with a window clear that still accepts a same-edge pulse.
module done_ch_counter #(
  parameter int TARGET = 12,
  parameter int CNT_W = $clog2(TARGET + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic full,
  output logic full_nxt,
  output logic drop
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (clr) cnt <= CNT_W'(inc);
    else if (inc && !full) cnt <= cnt + 1'b1;
  assign full = cnt == CNT_W'(TARGET);
  assign full_nxt = full | (inc & (cnt == CNT_W'(TARGET - 1)));
  assign drop = inc & full & ~clr;
endmodule

// File: rtl/done_tracker.sv
// done_tracker: counts per-channel MAC done pulses and raises en_y until acked; DONE_TRACKER_OVF_EN enables the sticky overflow flag.
module done_tracker
  import systolic_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DONE_TARGET = DONE_TARGET_DEF,
  parameter int CNT_W = $clog2(DONE_TARGET + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] done,
  input  logic              clear,
  input  logic              en_ack,
  output logic              en_y,
  output logic [NUM_CH-1:0] ch_full,
  output logic              overflow
);
  done_state_e state;
  logic [NUM_CH-1:0] full, full_nxt, drop;
  logic wipe, ack;
  assign wipe = reset | clear;
  assign ack = (state == ST_FIRE) & en_ack;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    done_ch_counter #(.TARGET(DONE_TARGET), .CNT_W(CNT_W)) u_cnt (
      .clk(clk), .reset(wipe), .clr(ack), .inc(done[g]),
      .full(full[g]), .full_nxt(full_nxt[g]), .drop(drop[g])
    );
  end
  // counters are all full while firing, so unacked pulses there surface as drops too
  always_ff @(posedge clk)
    if (wipe) state <= ST_COUNT;
    else if (state == ST_COUNT) state <= &full_nxt ? ST_FIRE : ST_COUNT;
    else state <= en_ack ? ST_COUNT : ST_FIRE;
  assign en_y = state == ST_FIRE;
  assign ch_full = full;
`ifdef DONE_TRACKER_OVF_EN
  always_ff @(posedge clk)
    if (wipe) overflow <= 1'b0;
    else overflow <= overflow | (|drop);
`else
  logic unused_drop;
  assign unused_drop = |drop;
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_done_tracker.sv
// tb_done_tracker: window-level model comparison every cycle plus directed literal checks.
module tb_done_tracker;
`ifdef DONE_TRACKER_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, clear = 1'b0, en_ack = 1'b0, started = 1'b0;
  logic [3:0] done = '0, ch_full;
  logic [1:0] done_b = '0, ch_full_b;
  logic en_y, overflow, en_y_b, overflow_b;
  int pass = 0, total = 0;
  always #5 clk = ~clk;

  done_tracker dut (.clk(clk), .reset(reset), .done(done), .clear(clear), .en_ack(en_ack),
    .en_y(en_y), .ch_full(ch_full), .overflow(overflow));
  done_tracker #(.NUM_CH(2), .DONE_TARGET(1)) dut_b (.clk(clk), .reset(reset), .done(done_b),
    .clear(1'b0), .en_ack(1'b1), .en_y(en_y_b), .ch_full(ch_full_b), .overflow(overflow_b));

  typedef struct { int cnt [4]; bit fire; bit ovf; } mst_t;
  mst_t ma, mb;

  function automatic mst_t step(mst_t s, int n, int t, bit rs, logic [3:0] d, bit a);
    mst_t r;
    bit all;
    r = s;
    all = 1'b1;
    if (rs) begin
      for (int i = 0; i < 4; i++) r.cnt[i] = 0;
      r.fire = 0;
      r.ovf = 0;
    end else if (!r.fire) begin
      for (int i = 0; i < n; i++) begin
        if (d[i]) begin
          if (r.cnt[i] < t) r.cnt[i]++;
          else r.ovf |= OVF;
        end
        all &= (r.cnt[i] == t);
      end
      r.fire = all;
    end else if (a) begin
      r.fire = 0;
      for (int i = 0; i < n; i++) r.cnt[i] = int'(d[i]);
    end else begin
      for (int i = 0; i < n; i++) if (d[i]) r.ovf |= OVF;
    end
    return r;
  endfunction

  function automatic logic [3:0] fullv(mst_t s, int n, int t);
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = (s.cnt[i] == t);
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin
    ma = step(ma, 4, 12, reset | clear, done, en_ack);
    mb = step(mb, 2, 1, reset, {2'b00, done_b}, 1'b1);
  end

  always @(negedge clk) if (started) begin
    check("m_en_y", en_y, ma.fire);
    check("m_ch_full", ch_full, fullv(ma, 4, 12));
    check("m_overflow", overflow, ma.ovf);
    check("mb_en_y", en_y_b, mb.fire);
    check("mb_ch_full", ch_full_b, fullv(mb, 2, 1) & 4'h3);
    check("mb_overflow", overflow_b, mb.ovf);
  end

  task automatic drive(input logic [3:0] d, input logic a, input logic c, input logic r);
    done = d;
    en_ack = a;
    clear = c;
    reset = r;
    @(posedge clk);
    #1;
    done = '0;
    en_ack = 1'b0;
    clear = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin ma.cnt[i] = 0; mb.cnt[i] = 0; end
    ma.fire = 0; ma.ovf = 0; mb.fire = 0; mb.ovf = 0;
    drive(4'h0, 0, 0, 1);
    drive(4'h0, 0, 0, 1);
    started = 1'b1;
    check("rst_en_y", en_y, 0);
    check("rst_ch_full", ch_full, 4'h0);
    check("rst_overflow", overflow, 0);
    for (int k = 0; k < 47; k++) drive(4'h1 << (k % 4), 0, 0, 0);
    check("pre48_en_y", en_y, 0);
    check("pre48_ch_full", ch_full, 4'h7);
    drive(4'h8, 0, 0, 0);
    check("fire_en_y", en_y, 1);
    check("fire_ch_full", ch_full, 4'hF);
    repeat (20) drive(4'h0, 0, 0, 0);
    check("hold_en_y", en_y, 1);
    drive(4'h5, 1, 0, 0);
    check("ack_en_y", en_y, 0);
    check("ack_ch_full", ch_full, 4'h0);
    repeat (11) drive(4'h5, 0, 0, 0);
    check("carry_ch_full", ch_full, 4'h5);
    repeat (11) drive(4'hA, 0, 0, 0);
    check("carry_pre_en_y", en_y, 0);
    drive(4'hA, 0, 0, 0);
    check("carry_en_y", en_y, 1);
    drive(4'h0, 1, 0, 0);
    check("ack2_en_y", en_y, 0);
    repeat (5) drive(4'hF, 0, 0, 0);
    repeat (7) drive(4'h1, 0, 0, 0);
    check("sat_ch_full", ch_full, 4'h1);
    check("sat_overflow", overflow, 0);
    drive(4'h1, 0, 0, 0);
    check("drop_overflow", overflow, OVF);
    check("drop_en_y", en_y, 0);
    check("drop_ch_full", ch_full, 4'h1);
    repeat (6) drive(4'hE, 0, 0, 0);
    check("fill_pre_en_y", en_y, 0);
    drive(4'hE, 0, 0, 0);
    check("fill_en_y", en_y, 1);
    drive(4'h3, 0, 0, 0);
    check("fire_drop_en_y", en_y, 1);
    check("fire_drop_ch_full", ch_full, 4'hF);
    check("fire_drop_overflow", overflow, OVF);
    drive(4'h0, 0, 1, 0);
    check("clr_en_y", en_y, 0);
    check("clr_overflow", overflow, 0);
    check("clr_ch_full", ch_full, 4'h0);
    repeat (11) drive(4'hF, 0, 0, 0);
    check("refill_pre_en_y", en_y, 0);
    drive(4'hF, 0, 0, 0);
    check("refill_en_y", en_y, 1);
    drive(4'h0, 1, 0, 0);
    repeat (12) drive(4'h1, 0, 0, 0);
    check("rc_pre_ch_full", ch_full, 4'h1);
    done = 4'h1;
    clear = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    done = '0; clear = 1'b0; reset = 1'b0;
    check("rc_ch_full", ch_full, 4'h0);
    check("rc_en_y", en_y, 0);
    done_b = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("b_toggle_en_y", en_y_b, (k % 2 == 0) ? 1 : 0);
    end
    done_b = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
